dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the single-cycle RV32 core's load/store port. It accepts one load or store request at a time over a valid/ready request channel, waits a programmable latency, and performs the access on an internal word-organised little-endian SRAM. Byte lanes are selected by address and funct3, and loads are sign- or zero-extended. It returns read data or an error flag over a valid/ready response channel, so the core's fetch/execute side can be stalled by a realistic memory instead of an ideal combinational array.

## Interface
- ADDR_W, 10: word-index width; capacity is 2^ADDR_W words (4 KiB at the default).
- LATENCY, 2: cycles from request accept to rsp_valid; legal range 1..15.
- BASE, 32'h8000_0000: byte address of word 0.

- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder idle, request accepted when both high at posedge
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_funct3  in  3  RV32 funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response when both high at posedge
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or illegal funct3

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - BUSY: latency countdown.
  - RESP: rsp_valid=1.
- IDLE -> BUSY on req_valid&&req_ready. At that edge, capture wen, addr, wdata and funct3, and load the 4-bit counter with LATENCY-1.
- BUSY, counter≠0: decrement.
- BUSY, counter==0: perform the access, register rsp_rdata/rsp_err, then go to RESP.
- RESP -> IDLE on rsp_ready. rsp_valid, rsp_rdata and rsp_err stay stable until that edge.
- Error check, evaluated on captured fields:
  - Out of range: (addr-BASE) ≥ 4·2^ADDR_W, using 32-bit unsigned subtraction, so an addr below BASE wraps and is also out of range.
  - Misaligned: half access with addr[0]≠0, or word access with addr[1:0]≠0.
  - Illegal funct3: load 3/6/7, or store 3..7.
  - On error: no memory write, rsp_rdata=0, rsp_err=1.
- Word index = (addr-BASE)[ADDR_W+1:2]. Lane = addr[1:0].
- Stores use a byte-enable write:
  - SB: lane addr[1:0] ← wdata[7:0].
  - SH: lanes {addr[1],0} and {addr[1],1} ← wdata[15:0].
  - SW: all four lanes.
  - Other lanes are unchanged.
- Loads:
  - LB/LBU: byte at lane, sign- or zero-extended.
  - LH/LHU: half at addr[1], sign- or zero-extended.
  - LW: full word.
- A store is visible to every request accepted after its response is issued; there is no overlap, so there are no hazards.
- Memory contents are not cleared by reset; contents before the first write are undefined (the bench preloads or writes first).

## Timing
- Reset values (while rst low, asynchronously): state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- req_ready is registered: it rises at the first posedge after rst deasserts, and drops at the accept edge.
- Accept at edge k → rsp_valid high after edge k+LATENCY. The memory read/write occurs at edge k+LATENCY.
- Minimum occupancy per transaction is LATENCY+1 cycles (response taken at edge k+LATENCY+1, next accept at k+LATENCY+2 at the earliest). req_ready returns the cycle after the response handshake.
- Request or response behaviour outside its accept state:
  - req_valid while not IDLE is ignored, not queued.
  - Request inputs may change freely outside the accept edge.
  - rsp_ready outside RESP is ignored.
- Reset asserted in BUSY: the transaction is aborted, the pending store is not written, and no response is produced.
- Reset asserted in RESP: the response is dropped; a store already written stays written.

## Test plan
- Reset: hold rst low 3 cycles with req_valid=1 → all outputs 0, no accept. Release → req_ready=1 after the first posedge.
- SW 0x8000_0010 ← 0xDEADBEEF, then LW 0x8000_0010 → rsp_rdata=0xDEADBEEF, rsp_err=0. Each rsp_valid rises exactly 2 cycles after its accept edge (LATENCY=2); rerun with LATENCY=1 → 1 cycle.
- After the SW above, SB 0x8000_0011 ← 0x0000_00A5. Then:
  - LB 0x8000_0011 → 0xFFFF_FFA5
  - LBU 0x8000_0011 → 0x0000_00A5
  - LW 0x8000_0010 → 0xDEAD_A5EF
  - LH 0x8000_0012 → 0xFFFF_DEAD
  - LHU 0x8000_0012 → 0x0000_DEAD
- Errors:
  - LH 0x8000_0011 → err=1, rdata=0.
  - SW 0x8000_1000 ← 0x1234_5678 → err=1. A following LW 0x8000_0000 is unchanged.
  - funct3=3 load → err=1.
  - LW 0x7FFF_FFFC → err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_rdata and rsp_err are constant, req_ready=0, and a concurrent req_valid is not accepted. Then rsp_ready=1 → IDLE the next cycle.
- Reset mid-operation: SW 0x8000_0020 ← 0x1111_1111, then SW 0x8000_0020 ← 0x2222_2222 with rst pulsed low in BUSY → no response. A subsequent LW 0x8000_0020 → 0x1111_1111.

Source files
------------

// File: rtl/dmem_responder.sv
// Latency-programmable data-memory responder for the RV32 load/store port.
// One transaction at a time: valid/ready request in, byte-lane SRAM access, valid/ready response out.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2,
  parameter logic [31:0] BASE    = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Words    = 2 ** ADDR_W;
  localparam logic [31:0] MemBytes = 32'(4 * Words);
  localparam logic [3:0]  CntInit  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;

  logic              accept;
  logic              access;
  logic [31:0]       offset;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              out_of_range;
  logic              misaligned;
  logic              illegal;
  logic              err;
  logic [31:0]       mem_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       load_data;
  logic [31:0]       store_data;
  logic [3:0]        store_be;
  logic              mem_we;

  logic [31:0] mem [Words];

  assign accept = (state_q == StIdle) && req_ready_q && req_valid;
  assign access = (state_q == StBusy) && (cnt_q == 4'd0);

  // Addresses below BASE wrap to huge offsets and fail the range check.
  assign offset       = addr_q - BASE;
  assign out_of_range = offset >= MemBytes;
  assign word_idx     = offset[ADDR_W+1:2];
  assign lane         = addr_q[1:0];

  assign illegal    = wen_q ? (funct3_q > 3'd2) : (funct3_q inside {3'd3, 3'd6, 3'd7});
  assign misaligned = ((funct3_q[1:0] == 2'd1) && addr_q[0]) ||
                      ((funct3_q[1:0] == 2'd2) && (lane != 2'd0));
  assign err        = out_of_range || misaligned || illegal;

  assign mem_word = mem[word_idx];

  always_comb begin
    ld_byte = 8'h00;
    unique case (lane)
      2'd0: ld_byte = mem_word[7:0];
      2'd1: ld_byte = mem_word[15:8];
      2'd2: ld_byte = mem_word[23:16];
      2'd3: ld_byte = mem_word[31:24];
      default: ld_byte = 8'h00;
    endcase
  end

  assign ld_half = lane[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    load_data = 32'h0;
    case (funct3_q)
      3'd0: load_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1: load_data = {{16{ld_half[15]}}, ld_half};
      3'd2: load_data = mem_word;
      3'd4: load_data = {24'h0, ld_byte};
      3'd5: load_data = {16'h0, ld_half};
      default: load_data = 32'h0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    store_be   = 4'b1111;
    store_data = wdata_q;
    case (funct3_q[1:0])
      2'd0: begin
        store_be   = 4'b0001 << lane;
        store_data = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        store_be   = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  assign mem_we = access && wen_q && !err;

  // Memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (store_be[b]) begin
          mem[word_idx][b*8 +: 8] <= store_data[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          cnt_d   = CntInit;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StResp;
          err_d   = err;
          rdata_d = (err || wen_q) ? 32'h0 : load_data;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      cnt_q       <= 4'd0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      wen_q       <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      funct3_q    <= 3'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      if (accept) begin
        wen_q    <= req_wen;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one DUT at LATENCY=2 and one at LATENCY=1,
// selected by sel_l1 onto a shared stimulus bus.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        sel_l1;
  logic        req_valid;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_ready;

  logic        d0_req_ready, d0_rsp_valid, d0_rsp_err;
  logic [31:0] d0_rsp_rdata;
  logic        d1_req_ready, d1_rsp_valid, d1_rsp_err;
  logic [31:0] d1_rsp_rdata;

  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;

  int vectors;
  int miscompares;

  assign o_req_ready = sel_l1 ? d1_req_ready : d0_req_ready;
  assign o_rsp_valid = sel_l1 ? d1_rsp_valid : d0_rsp_valid;
  assign o_rsp_rdata = sel_l1 ? d1_rsp_rdata : d0_rsp_rdata;
  assign o_rsp_err   = sel_l1 ? d1_rsp_err   : d0_rsp_err;

  dmem_responder #(.ADDR_W(10), .LATENCY(2), .BASE(32'h8000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid & ~sel_l1),
    .req_ready  (d0_req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (d0_rsp_valid),
    .rsp_ready  (rsp_ready & ~sel_l1),
    .rsp_rdata  (d0_rsp_rdata),
    .rsp_err    (d0_rsp_err)
  );

  dmem_responder #(.ADDR_W(10), .LATENCY(1), .BASE(32'h8000_0000)) dut_l1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid & sel_l1),
    .req_ready  (d1_req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (d1_rsp_valid),
    .rsp_ready  (rsp_ready & sel_l1),
    .rsp_rdata  (d1_rsp_rdata),
    .rsp_err    (d1_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one full transaction; lat = edges from accept to rsp_valid.
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                        output int lat);
    int n;
    req_wen    = wen;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    req_valid  = 1'b1;
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (!o_req_ready) begin
      miscompares++;
      $display("FAIL req_ready_timeout: req_ready=%0b required 1", o_req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!o_rsp_valid && lat < 20);
    vectors++;
    if (!o_rsp_valid) begin
      miscompares++;
      $display("FAIL rsp_valid_timeout: rsp_valid=%0b required 1", o_rsp_valid);
    end
    rdata = o_rsp_rdata;
    err   = o_rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata} !== 35'h0) begin
        miscompares++;
        $display("FAIL reset_outputs: ready=%0b valid=%0b err=%0b rdata=%h required all 0",
                 o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata);
      end
    end
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (o_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_ready: req_ready=%0b required 0", o_req_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_first_edge: req_ready=%0b rsp_valid=%0b required 1/0",
               o_req_ready, o_rsp_valid);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'd2, rd, er, lat);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== 2) begin
      miscompares++;
      $display("FAIL sw_basic: rdata=%h err=%0b lat=%0d required 00000000/0/2", rd, er, lat);
    end
    do_req(1'b0, 32'h8000_0010, 32'h0, 3'd2, rd, er, lat);
    vectors++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat !== 2) begin
      miscompares++;
      $display("FAIL lw_basic: rdata=%h err=%0b lat=%0d required deadbeef/0/2", rd, er, lat);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] addrs [5] = '{32'h8000_0011, 32'h8000_0011, 32'h8000_0010,
                               32'h8000_0012, 32'h8000_0012};
    logic [2:0]  f3s   [5] = '{3'd0, 3'd4, 3'd2, 3'd1, 3'd5};
    logic [31:0] exps  [5] = '{32'hFFFF_FFA5, 32'h0000_00A5, 32'hDEAD_A5EF,
                               32'hFFFF_DEAD, 32'h0000_DEAD};
    do_req(1'b1, 32'h8000_0011, 32'h0000_00A5, 3'd0, rd, er, lat);
    vectors++;
    if (er !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_lane1_err: err=%0b required 0", er);
    end
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, addrs[i], 32'h0, f3s[i], rd, er, lat);
      vectors++;
      if (rd !== exps[i] || er !== 1'b0) begin
        miscompares++;
        $display("FAIL load_lane_%0d: rdata=%h err=%0b required %h/0", i, rd, er, exps[i]);
      end
    end
    do_req(1'b1, 32'h8000_0016, 32'hFFFF_1357, 3'd1, rd, er, lat);
    do_req(1'b0, 32'h8000_0014, 32'h0, 3'd2, rd, er, lat);
    vectors++;
    if (rd[31:16] !== 16'h1357 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL sh_upper: rdata[31:16]=%h err=%0b required 1357/0", rd[31:16], er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b1, 32'h8000_0000, 32'hCAFE_F00D, 3'd2, rd, er, lat);
    do_req(1'b0, 32'h8000_0011, 32'h0, 3'd1, rd, er, lat);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      miscompares++;
      $display("FAIL lh_misaligned: rdata=%h err=%0b required 00000000/1", rd, er);
    end
    do_req(1'b1, 32'h8000_1000, 32'h1234_5678, 3'd2, rd, er, lat);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL sw_out_of_range: err=%0b required 1", er);
    end
    do_req(1'b0, 32'h8000_0000, 32'h0, 3'd2, rd, er, lat);
    vectors++;
    if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
      miscompares++;
      $display("FAIL word0_unchanged: rdata=%h err=%0b required cafef00d/0", rd, er);
    end
    do_req(1'b0, 32'h8000_0000, 32'h0, 3'd3, rd, er, lat);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      miscompares++;
      $display("FAIL load_funct3_3: rdata=%h err=%0b required 00000000/1", rd, er);
    end
    do_req(1'b1, 32'h8000_0000, 32'h5555_5555, 3'd4, rd, er, lat);
    vectors++;
    if (er !== 1'b1) begin
      miscompares++;
      $display("FAIL store_funct3_4: err=%0b required 1", er);
    end
    do_req(1'b0, 32'h7FFF_FFFC, 32'h0, 3'd2, rd, er, lat);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      miscompares++;
      $display("FAIL lw_below_base: rdata=%h err=%0b required 00000000/1", rd, er);
    end
    do_req(1'b1, 32'h8000_0FFC, 32'h0BAD_C0DE, 3'd2, rd, er, lat);
    do_req(1'b0, 32'h8000_0FFC, 32'h0, 3'd2, rd, er, lat);
    vectors++;
    if (rd !== 32'h0BAD_C0DE || er !== 1'b0) begin
      miscompares++;
      $display("FAIL last_word: rdata=%h err=%0b required 0badc0de/0", rd, er);
    end
    do_req(1'b0, 32'h8000_0000, 32'h0, 3'd2, rd, er, lat);
    vectors++;
    if (rd !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL word0_after_store_err: rdata=%h required cafef00d", rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    req_wen = 1'b0; req_addr = 32'h8000_0010; req_funct3 = 3'd2; req_valid = 1'b1;
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    // A competing store stays asserted for the whole stall.
    req_wen = 1'b1; req_wdata = 32'h0BAD_0BAD;
    n = 0;
    while (!o_rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'hDEAD_A5EF || o_rsp_err !== 1'b0 ||
          o_req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_cycle_%0d: valid=%0b rdata=%h err=%0b ready=%0b required 1/dead_a5ef/0/0",
                 i, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_req_ready);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: valid=%0b ready=%0b required 0/1", o_rsp_valid, o_req_ready);
    end
    do_req(1'b0, 32'h8000_0010, 32'h0, 3'd2, rd, er, lat);
    vectors++;
    if (rd !== 32'hDEAD_A5EF) begin
      miscompares++;
      $display("FAIL stall_store_ignored: rdata=%h required dead_a5ef", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    do_req(1'b1, 32'h8000_0020, 32'h1111_1111, 3'd2, rd, er, lat);
    req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h2222_2222; req_funct3 = 3'd2;
    req_valid = 1'b1;
    n = 0;
    while (!o_req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_reset_async: valid=%0b ready=%0b required 0/0", o_rsp_valid, o_req_ready);
    end
    #2;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (o_rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_reset_no_rsp_%0d: rsp_valid=%0b required 0", i, o_rsp_valid);
      end
    end
    do_req(1'b0, 32'h8000_0020, 32'h0, 3'd2, rd, er, lat);
    vectors++;
    if (rd !== 32'h1111_1111 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_reset_store_dropped: rdata=%h err=%0b required 11111111/0", rd, er);
    end
  endtask

  task automatic test_latency1();
    logic [31:0] rd;
    logic        er;
    int          lat;
    sel_l1 = 1'b1;
    #1;
    do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'd2, rd, er, lat);
    vectors++;
    if (lat !== 1 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL l1_sw: lat=%0d err=%0b required 1/0", lat, er);
    end
    do_req(1'b0, 32'h8000_0010, 32'h0, 3'd2, rd, er, lat);
    vectors++;
    if (lat !== 1 || rd !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL l1_lw: lat=%0d rdata=%h required 1/deadbeef", lat, rd);
    end
    sel_l1 = 1'b0;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sel_l1      = 1'b0;
    rst         = 1'b0;
    req_valid   = 1'b0;
    req_wen     = 1'b0;
    req_addr    = 32'h0;
    req_wdata   = 32'h0;
    req_funct3  = 3'd0;
    rsp_ready   = 1'b0;
    #1;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_latency1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
